// File: rtl/rr_mux4_arb.sv
// Round-robin arbiter that shares one 4:1 data mux among four requesters.
// It caps grant length at MAXHOLD cycles and registers the forwarded data.
module rr_mux4_arb #(
  parameter int W       = 1,
  parameter int MAXHOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] d,
  output logic [3:0]     gnt,
  output logic [1:0]     a,
  output logic [W-1:0]   y,
  output logic           vld
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAXHOLD);

  state_t       state, state_nxt;
  logic [1:0]   ptr, ptr_nxt;
  logic [1:0]   a_nxt;
  logic [3:0]   gnt_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic [1:0]   base;
  logic [1:0]   winner;
  logic         found;
  logic         hold;
  logic         beat;
  logic [W-1:0] d_sel;

  // On release the search starts just past the releasing requester, so it is scanned last.
  assign base = (state == GRANT) ? a + 2'd1 : ptr;

  always_comb begin
    found  = 1'b0;
    winner = base;
    for (int k = 3; k >= 0; k--) begin
      if (req[base + 2'(k)]) begin
        found  = 1'b1;
        winner = base + 2'(k);
      end
    end
  end

  always_comb begin
    d_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (a == 2'(i)) d_sel = d[i*W +: W];
    end
  end

  assign hold = req[a] && (cnt < MAX_CNT);
  assign beat = (state == GRANT) && req[a];

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    a_nxt     = a;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        gnt_nxt = 4'b0000;
        if (found) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << winner;
          a_nxt     = winner;
          cnt_nxt   = 4'd1;
        end
      end
      GRANT: begin
        if (hold) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          ptr_nxt = a + 2'd1;
          if (found) begin
            gnt_nxt = 4'b0001 << winner;
            a_nxt   = winner;
            cnt_nxt = 4'd1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            cnt_nxt   = 4'd0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  // y only updates on an accepted beat; otherwise it holds the last forwarded value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      a     <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
      y     <= '0;
      vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      a     <= a_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      vld   <= beat;
      if (beat) y <= d_sel;
    end
  end

endmodule

// File: tb/tb_rr_mux4_arb.sv
// Directed bench for rr_mux4_arb: one instance with MAXHOLD=4, one with MAXHOLD=2,
// both driven by the same inputs and checked against hand-computed values.
module tb_rr_mux4_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;

  logic [3:0] gnt_o [2];
  logic [1:0] a_o   [2];
  logic [0:0] y_o   [2];
  logic       vld_o [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Index 0 holds grants up to 4 cycles, index 1 up to 2 cycles.
  rr_mux4_arb #(.W(1), .MAXHOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .d(d),
    .gnt(gnt_o[0]), .a(a_o[0]), .y(y_o[0]), .vld(vld_o[0])
  );

  rr_mux4_arb #(.W(1), .MAXHOLD(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .d(d),
    .gnt(gnt_o[1]), .a(a_o[1]), .y(y_o[1]), .vld(vld_o[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    d   = 4'b1111;
    tick();
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt u=%0d got=%b want=0000", u, gnt_o[u]); end
      total++;
      if (a_o[u] !== 2'd0) begin bad++; $display("[TB] FAIL reset_a u=%0d got=%0d want=0", u, a_o[u]); end
      total++;
      if (vld_o[u] !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld u=%0d got=%b want=0", u, vld_o[u]); end
      total++;
      if (y_o[u] !== 1'b0) begin bad++; $display("[TB] FAIL reset_y u=%0d got=%b want=0", u, y_o[u]); end
    end
    rst = 1'b0;
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b0001) begin bad++; $display("[TB] FAIL post_reset_gnt u=%0d got=%b want=0001", u, gnt_o[u]); end
      total++;
      if (a_o[u] !== 2'd0) begin bad++; $display("[TB] FAIL post_reset_a u=%0d got=%0d want=0", u, a_o[u]); end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    d   = 4'b0100;
    for (int e = 1; e <= 10; e++) begin
      tick();
      for (int u = 0; u < 2; u++) begin
        total++;
        if (gnt_o[u] !== 4'b0100 || a_o[u] !== 2'd2) begin
          bad++; $display("[TB] FAIL single_gnt u=%0d edge=%0d got=%b/%0d want=0100/2", u, e, gnt_o[u], a_o[u]);
        end
        total++;
        if (vld_o[u] !== (e > 1)) begin
          bad++; $display("[TB] FAIL single_vld u=%0d edge=%0d got=%b want=%b", u, e, vld_o[u], (e > 1));
        end
        if (e > 1) begin
          total++;
          if (y_o[u] !== 1'b1) begin bad++; $display("[TB] FAIL single_y u=%0d edge=%0d got=%b want=1", u, e, y_o[u]); end
        end
      end
    end
  endtask

  task automatic test_fairness();
    int seq4 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
    int seq2 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp_a;
    int prev_a;
    do_reset();
    req = 4'b1111;
    d   = 4'b1010;
    for (int e = 0; e < 10; e++) begin
      tick();
      for (int u = 0; u < 2; u++) begin
        exp_a = (u == 0) ? seq4[e] : seq2[e];
        total++;
        if (a_o[u] !== 2'(exp_a) || gnt_o[u] !== (4'b0001 << exp_a)) begin
          bad++; $display("[TB] FAIL rr_grant u=%0d edge=%0d got=%b/%0d want_a=%0d", u, e + 1, gnt_o[u], a_o[u], exp_a);
        end
        if (e > 0) begin
          prev_a = (u == 0) ? seq4[e-1] : seq2[e-1];
          total++;
          if (vld_o[u] !== 1'b1 || y_o[u] !== d[prev_a]) begin
            bad++; $display("[TB] FAIL rr_data u=%0d edge=%0d got=%b/%b want=1/%b", u, e + 1, vld_o[u], y_o[u], d[prev_a]);
          end
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    d   = 4'b0010;
    req = 4'b0010;
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b0010 || a_o[u] !== 2'd1 || vld_o[u] !== 1'b0) begin
        bad++; $display("[TB] FAIL early_first u=%0d got=%b/%0d/%b want=0010/1/0", u, gnt_o[u], a_o[u], vld_o[u]);
      end
    end
    req = 4'b1010;
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b0010 || vld_o[u] !== 1'b1 || y_o[u] !== 1'b1) begin
        bad++; $display("[TB] FAIL early_beat u=%0d got=%b/%b/%b want=0010/1/1", u, gnt_o[u], vld_o[u], y_o[u]);
      end
    end
    req = 4'b1000;
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b1000 || a_o[u] !== 2'd3) begin
        bad++; $display("[TB] FAIL early_switch u=%0d got=%b/%0d want=1000/3", u, gnt_o[u], a_o[u]);
      end
      total++;
      if (vld_o[u] !== 1'b0 || y_o[u] !== 1'b1) begin
        bad++; $display("[TB] FAIL early_drop u=%0d vld/y got=%b/%b want=0/1", u, vld_o[u], y_o[u]);
      end
    end
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (vld_o[u] !== 1'b1 || y_o[u] !== 1'b0) begin
        bad++; $display("[TB] FAIL early_next u=%0d vld/y got=%b/%b want=1/0", u, vld_o[u], y_o[u]);
      end
    end
  endtask

  // Continues from the grant on requester 3 left by test_early_release.
  task automatic test_wrap_idle();
    req = 4'b0000;
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b0000 || a_o[u] !== 2'd3 || vld_o[u] !== 1'b0) begin
        bad++; $display("[TB] FAIL idle_enter u=%0d got=%b/%0d/%b want=0000/3/0", u, gnt_o[u], a_o[u], vld_o[u]);
      end
    end
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b0000 || vld_o[u] !== 1'b0) begin
        bad++; $display("[TB] FAIL idle_stay u=%0d got=%b/%b want=0000/0", u, gnt_o[u], vld_o[u]);
      end
    end
    req = 4'b1001;
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b0001 || a_o[u] !== 2'd0) begin
        bad++; $display("[TB] FAIL wrap_grant u=%0d got=%b/%0d want=0001/0", u, gnt_o[u], a_o[u]);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    d   = 4'b0100;
    req = 4'b0010;
    tick();
    req = 4'b0100;
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b0100 || a_o[u] !== 2'd2) begin
        bad++; $display("[TB] FAIL mid_setup u=%0d got=%b/%0d want=0100/2", u, gnt_o[u], a_o[u]);
      end
    end
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (vld_o[u] !== 1'b1 || y_o[u] !== 1'b1) begin
        bad++; $display("[TB] FAIL mid_beat u=%0d got=%b/%b want=1/1", u, vld_o[u], y_o[u]);
      end
    end
    rst = 1'b1;
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b0000 || a_o[u] !== 2'd0 || vld_o[u] !== 1'b0 || y_o[u] !== 1'b0) begin
        bad++; $display("[TB] FAIL mid_reset u=%0d got=%b/%0d/%b/%b want=0000/0/0/0", u, gnt_o[u], a_o[u], vld_o[u], y_o[u]);
      end
    end
    rst = 1'b0;
    req = 4'b0110;
    tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (gnt_o[u] !== 4'b0010 || a_o[u] !== 2'd1) begin
        bad++; $display("[TB] FAIL mid_regrant u=%0d got=%b/%0d want=0010/1", u, gnt_o[u], a_o[u]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    d   = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_early_release();
    test_wrap_idle();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arb.md
Name: rr_mux4_arb

Overview:
- Round-robin arbiter that shares one 4:1 data multiplexer between four requesters.
- Selects one requester at a time and drives the 2-bit mux select and one-hot grant.
- Forwards the granted requester's data to a single registered output with a valid flag.
- Caps consecutive grant length so no requester starves the others.

Parameters:
- W, 1: data width per requester.
- MAXHOLD, 4: maximum consecutive cycles one grant is held; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines, req[i] for requester i.
- d  input  4*W  requester data; d[i*W +: W] belongs to requester i.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- a  output  2  mux select = index of granted requester, registered.
- y  output  W  forwarded data, registered.
- vld  output  1  y carries a valid beat.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, gnt=0, a=0, ptr=0, cnt=0, y=0, vld=0.
- Reset has priority over every other event.
- Reset asserted mid-grant clears everything at that edge. The beat sampled on that edge is dropped, so vld=0 on the next cycle.
- Internal state: state in {IDLE, GRANT}, ptr[1:0] (round-robin priority start), cnt (4 bits, cycles in current grant).
- Winner search: scan req starting at index ptr, upward mod 4. The first set bit wins.
- IDLE:
  - req==0: stay in IDLE, gnt=0.
  - req!=0: at the edge, gnt <= onehot(winner), a <= winner, cnt <= 1, state <= GRANT.
- GRANT, hold conditions: req[a]=1 and cnt<MAXHOLD. At the edge, cnt <= cnt+1 and the grant is unchanged.
- GRANT, release conditions: req[a]=0, or cnt==MAXHOLD.
  - ptr becomes a+1 mod 4; the winner search uses this new ptr in the same cycle.
  - The releasing requester is searched last, so it regains the grant only if no other request is set.
  - Winner exists: gnt/a <= winner, cnt <= 1, state stays GRANT. There is no idle bubble between grants.
  - No request set: gnt <= 0, state <= IDLE. a keeps its last value.
- Data path, 1-cycle latency:
  - At each edge, y <= d[a*W +: W] and vld <= (state==GRANT && req[a]).
  - When that condition is false, vld <= 0 and y holds its previous value.
- Beat definition: a beat is accepted in any cycle where gnt[i]=1 and req[i]=1. A requester must treat that cycle as consumed.
- Requests are level-sensitive. Dropping req[a] ends the grant at that edge with no beat for that cycle.
- ptr only updates on release, never in IDLE. Wrap-around from a=3 gives ptr=0.
- gnt is always one-hot or zero. a always matches the set gnt bit while in GRANT.
- Width rules: cnt saturation is not needed because release occurs at MAXHOLD.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'b1111 -> gnt=0, a=0, vld=0, y=0. Release rst -> next edge gnt=4'b0001, a=0.
- Single requester: req=4'b0100, d[2]=1, W=1, MAXHOLD=4, held 10 cycles -> gnt=4'b0100 for 4 cycles. After release, a re-grant to 2 with no bubble. vld=1 from the cycle after the first grant; y=1 throughout.
- Round-robin fairness: req=4'b1111 steady, MAXHOLD=2 -> grant sequence 0,0,1,1,2,2,3,3,0,0. Each change occurs with no idle cycle.
- Early release: requester 1 granted, drops req after 1 beat while req[3]=1 -> next edge gnt=4'b1000, a=3. vld is 0 for the dropped cycle.
- Wrap and idle: grant on 3 releases with req=0 -> gnt=0, state IDLE, vld=0 next cycle. Later req=4'b1001 -> grant 0 (ptr wrapped to 0).
- Reset mid-grant: rst=1 during cnt=2 on requester 2 -> next cycle gnt=0, vld=0, ptr=0. After rst drops with req=4'b0110, grant goes to 1.
